// File: rtl/core_pipe_cf_arbiter.sv
// Control-flow redirect arbiter: picks one of trap/exec/restart requests, holds it
// on the registered fetch bus until fetch accepts it, and counts completed redirects.
module core_pipe_cf_arbiter #(
  parameter int XL    = 63,
  parameter int CNT_W = 32
) (
  input  logic          g_clk,
  input  logic          g_reset,
  input  logic          trap_cf_valid,
  input  logic [XL:0]   trap_cf_target,
  output logic          trap_cf_ack,
  input  logic          exec_cf_valid,
  input  logic [XL:0]   exec_cf_target,
  output logic          exec_cf_ack,
  input  logic          rst_cf_valid,
  input  logic [XL:0]   rst_cf_target,
  output logic          rst_cf_ack,
  output logic          f_cf_valid,
  output logic [XL:0]   f_cf_target,
  input  logic          f_cf_ack,
  output logic [CNT_W-1:0] cf_count
);

  typedef enum logic [0:0] {IDLE, HOLD} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_TRAP, OWN_EXEC, OWN_RST} owner_t;

  state_t            r_state;
  owner_t            r_owner;
  logic              r_valid;
  logic [XL:0]       r_target;
  logic [CNT_W-1:0]  r_count;

  logic [2:0]        w_req;
  owner_t            w_winner;
  logic [XL:0]       w_winTarget;
  logic              w_accept;

  assign w_accept = r_valid && f_cf_ack;

  // While holding, the current owner still shows valid in its ack cycle, so it is masked out.
  always_comb begin
    w_req       = {rst_cf_valid, exec_cf_valid, trap_cf_valid};
    w_winner    = OWN_NONE;
    w_winTarget = '0;
    if (r_state == HOLD) begin
      case (r_owner)
        OWN_TRAP: w_req[0] = 1'b0;
        OWN_EXEC: w_req[1] = 1'b0;
        OWN_RST:  w_req[2] = 1'b0;
        default:  w_req    = w_req;
      endcase
    end
    if (w_req[0]) begin
      w_winner    = OWN_TRAP;
      w_winTarget = trap_cf_target;
    end else if (w_req[1]) begin
      w_winner    = OWN_EXEC;
      w_winTarget = exec_cf_target;
    end else if (w_req[2]) begin
      w_winner    = OWN_RST;
      w_winTarget = rst_cf_target;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state  <= IDLE;
      r_owner  <= OWN_NONE;
      r_valid  <= 1'b0;
      r_target <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_winner != OWN_NONE) begin
            r_state  <= HOLD;
            r_owner  <= w_winner;
            r_valid  <= 1'b1;
            r_target <= w_winTarget;
          end
        end
        HOLD: begin
          if (f_cf_ack) begin
            r_count <= r_count + CNT_W'(1);
            if (w_winner != OWN_NONE) begin
              r_owner  <= w_winner;
              r_target <= w_winTarget;
            end else begin
              r_state <= IDLE;
              r_owner <= OWN_NONE;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_owner <= OWN_NONE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign trap_cf_ack = w_accept && (r_owner == OWN_TRAP);
  assign exec_cf_ack = w_accept && (r_owner == OWN_EXEC);
  assign rst_cf_ack  = w_accept && (r_owner == OWN_RST);

  assign f_cf_valid  = r_valid;
  assign f_cf_target = r_target;
  assign cf_count    = r_count;

endmodule
